alu_cmd_issuer: RTL and testbench

Command-side initiator for the combinational ALU (operands a, b; 3-bit oper; result y). Accepts operation requests over a valid/ready command port, buffers them in a small FIFO, drives one request at a time onto registered ALU operand/opcode ports, samples the ALU result one cycle later, and returns it with a sequence tag over a valid/ready response port. It sits between a host/sequencer and the ALU, replacing ad-hoc direct driving of the ALU inputs.

---
 rtl/alu_cmd_issuer.sv | 163 ++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - queued command issuer for the combinational ALU
module alu_cmd_issuer #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [OPW-1:0]   cmd_oper,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_oper,
    input  logic [WIDTH-1:0] alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic [OPW-1:0]   rsp_oper,
    output logic [TAGW-1:0]  rsp_tag
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] fifo_a    [DEPTH];
    logic [WIDTH-1:0] fifo_b    [DEPTH];
    logic [OPW-1:0]   fifo_oper [DEPTH];
    logic [TAGW-1:0]  fifo_tag  [DEPTH];

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [TAGW-1:0] tag_cnt;
    logic [TAGW-1:0] cur_tag;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic capture;

    // Occupancy flags come only from the registered count, so a same-cycle pop never frees a slot early
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    // Command storage; entries need no reset because pointers and count define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr]    <= cmd_a;
            fifo_b[wr_ptr]    <= cmd_b;
            fifo_oper[wr_ptr] <= cmd_oper;
            fifo_tag[wr_ptr]  <= tag_cnt;
        end
    end

    // FIFO pointers, occupancy and the acceptance tag counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tag_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                tag_cnt <= tag_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus pop/capture strobes; a handshake in RESP may immediately issue the next command
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU operand registers hold the last issued command while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_oper <= '0;
            cur_tag  <= '0;
        end else if (pop) begin
            alu_a    <= fifo_a[rd_ptr];
            alu_b    <= fifo_b[rd_ptr];
            alu_oper <= fifo_oper[rd_ptr];
            cur_tag  <= fifo_tag[rd_ptr];
        end
    end

    // Response registers: load one cycle after issue, frozen until the consumer takes them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_oper  <= '0;
            rsp_tag   <= '0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_y     <= alu_y;
            rsp_oper  <= alu_oper;
            rsp_tag   <= cur_tag;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - self-checking bench for alu_cmd_issuer
module tb_alu_cmd_issuer;
    localparam int WIDTH = 32;
    localparam int OPW   = 3;
    localparam int DEPTH = 4;
    localparam int TAGW  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [OPW-1:0]   cmd_oper;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_oper;
    logic [WIDTH-1:0] alu_y;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic [OPW-1:0]   rsp_oper;
    logic [TAGW-1:0]  rsp_tag;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic [OPW-1:0]   op;
        logic [TAGW-1:0]  tag;
    } exp_t;

    exp_t             q[$];
    logic [TAGW-1:0]  tag_model;
    int               cycle_no;
    int               acc_count;
    int               rsp_cycles[$];
    logic [WIDTH-1:0] rsp_ys[$];
    logic [TAGW-1:0]  rsp_tags[$];
    logic             held;
    logic [WIDTH-1:0] held_y;
    logic [OPW-1:0]   held_op;
    logic [TAGW-1:0]  held_tag;

    alu_cmd_issuer #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_oper  (cmd_oper),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_oper  (alu_oper),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_oper  (rsp_oper),
        .rsp_tag   (rsp_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [OPW-1:0] op);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a * b;
            3'd3: r = (b == 0) ? '0 : a / b;
            3'd4: begin
                r = 1;
                for (int unsigned i = 0; i < b; i++) r = r * a;
            end
            3'd5: r = (b == 0) ? '0 : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Stand-in combinational ALU fed by the DUT's registered operands
    always_comb alu_y = alu_ref(alu_a, alu_b, alu_oper);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: called at negedge, applies inputs, scores handshakes, advances to next negedge
    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [OPW-1:0] op, input logic rr);
        exp_t e;
        cmd_valid = v;
        cmd_a     = a;
        cmd_b     = b;
        cmd_oper  = op;
        rsp_ready = rr;
        #1;
        if (held) begin
            chk("hold_valid", 64'(rsp_valid), 64'(1));
            chk("hold_y", 64'(rsp_y), 64'(held_y));
            chk("hold_oper", 64'(rsp_oper), 64'(held_op));
            chk("hold_tag", 64'(rsp_tag), 64'(held_tag));
        end
        if (cmd_valid && cmd_ready) begin
            q.push_back('{y: alu_ref(a, b, op), op: op, tag: tag_model});
            tag_model++;
            acc_count++;
        end
        if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                e = q.pop_front();
                chk("rsp_y", 64'(rsp_y), 64'(e.y));
                chk("rsp_oper", 64'(rsp_oper), 64'(e.op));
                chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                rsp_cycles.push_back(cycle_no);
                rsp_ys.push_back(rsp_y);
                rsp_tags.push_back(rsp_tag);
            end
        end
        held     = rsp_valid && !rsp_ready;
        held_y   = rsp_y;
        held_op  = rsp_oper;
        held_tag = rsp_tag;
        @(posedge clk);
        @(negedge clk);
        cycle_no++;
    endtask

    task automatic idle(input logic rr);
        drive(1'b0, '0, '0, '0, rr);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && q.size() != 0; i++) idle(1'b1);
        chk(tag, 64'(q.size()), 64'(0));
    endtask

    // Asynchronous reset asserted away from the clock edge; outputs must clear immediately
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_y", 64'(rsp_y), 64'(0));
        chk("rst_rsp_oper", 64'(rsp_oper), 64'(0));
        chk("rst_rsp_tag", 64'(rsp_tag), 64'(0));
        chk("rst_alu_a", 64'(alu_a), 64'(0));
        chk("rst_alu_b", 64'(alu_b), 64'(0));
        chk("rst_alu_oper", 64'(alu_oper), 64'(0));
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        rsp_cycles.delete();
        rsp_ys.delete();
        rsp_tags.delete();
        tag_model = '0;
        acc_count = 0;
        held      = 1'b0;
    endtask

    initial begin
        logic [OPW-1:0]   stream_ops [5];
        logic [WIDTH-1:0] stream_y   [5];
        logic             bp_ready   [5];
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [OPW-1:0]   rop;
        int               guard;

        stream_ops = '{3'd4, 3'd1, 3'd3, 3'd5, 3'd2};
        stream_y   = '{32'd100, 32'd8, 32'd5, 32'd0, 32'd20};
        bp_ready   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_oper = '0;
        cycle_no = 0; held = 1'b0; tag_model = '0; acc_count = 0;
        @(negedge clk);
        do_reset();

        // Single op: 10 - 2
        drive(1'b1, 32'd10, 32'd2, 3'd1, 1'b0);
        chk("single_alu_a_e0", 64'(alu_a), 64'(0));
        chk("single_rsp_valid_e0", 64'(rsp_valid), 64'(0));
        idle(1'b0);
        chk("single_alu_a_e1", 64'(alu_a), 64'(10));
        chk("single_alu_b_e1", 64'(alu_b), 64'(2));
        chk("single_alu_oper_e1", 64'(alu_oper), 64'(1));
        chk("single_rsp_valid_e1", 64'(rsp_valid), 64'(0));
        idle(1'b0);
        chk("single_rsp_valid_e2", 64'(rsp_valid), 64'(1));
        chk("single_rsp_y_e2", 64'(rsp_y), 64'(8));
        chk("single_rsp_oper_e2", 64'(rsp_oper), 64'(1));
        chk("single_rsp_tag_e2", 64'(rsp_tag), 64'(0));
        idle(1'b1);
        chk("single_rsp_valid_done", 64'(rsp_valid), 64'(0));
        chk("single_alu_a_kept", 64'(alu_a), 64'(10));

        // Stream with rsp_ready held high
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 32'd10, 32'd2, stream_ops[i], 1'b1);
        drain("stream_drain");
        chk("stream_count", 64'(rsp_ys.size()), 64'(5));
        if (rsp_ys.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("stream_y", 64'(rsp_ys[i]), 64'(stream_y[i]));
                chk("stream_tag", 64'(rsp_tags[i]), 64'(i));
            end
            for (int i = 1; i < 5; i++)
                chk("stream_spacing", 64'(rsp_cycles[i] - rsp_cycles[i-1]), 64'(2));
        end

        // Backpressure: fill to DEPTH with one in flight, then release
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, $urandom, 32'($urandom_range(1, 15)), 3'($urandom_range(0, 5)), 1'b0);
            chk("bp_cmd_ready", 64'(cmd_ready), 64'(bp_ready[i]));
        end
        chk("bp_accepted", 64'(acc_count), 64'(5));
        ra = $urandom; rb = 32'($urandom_range(1, 15)); rop = 3'($urandom_range(0, 5));
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ra, rb, rop, 1'b0);
            chk("bp_full_ready", 64'(cmd_ready), 64'(0));
        end
        chk("bp_no_push_when_full", 64'(acc_count), 64'(5));
        drive(1'b1, ra, rb, rop, 1'b1);
        chk("bp_ready_after_pop", 64'(cmd_ready), 64'(1));
        drive(1'b1, ra, rb, rop, 1'b0);
        chk("bp_sixth_accepted", 64'(acc_count), 64'(6));
        drain("bp_drain");
        chk("bp_rsp_count", 64'(rsp_ys.size()), 64'(6));

        // Simultaneous push and pop at occupancy 1
        do_reset();
        drive(1'b1, 32'd7, 32'd3, 3'd0, 1'b0);
        drive(1'b1, 32'd7, 32'd3, 3'd2, 1'b0);
        idle(1'b0);
        drive(1'b1, 32'd9, 32'd4, 3'd1, 1'b1);
        chk("pp_ready", 64'(cmd_ready), 64'(1));
        drive(1'b1, 32'd20, 32'd6, 3'd5, 1'b0);
        chk("pp_ready_occ2", 64'(cmd_ready), 64'(1));
        drive(1'b1, 32'd21, 32'd5, 3'd3, 1'b0);
        chk("pp_ready_occ3", 64'(cmd_ready), 64'(1));
        drive(1'b1, 32'd3, 32'd3, 3'd4, 1'b0);
        chk("pp_full_occ4", 64'(cmd_ready), 64'(0));
        drain("pp_drain");
        chk("pp_rsp_count", 64'(rsp_ys.size()), 64'(6));

        // Reset mid-transfer with three commands queued
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 32'd50 + 32'(i), 32'd2, 3'd0, 1'b0);
        do_reset();
        chk("mid_rst_ready", 64'(cmd_ready), 64'(1));
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            chk("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
        end
        drive(1'b1, 32'd6, 32'd7, 3'd2, 1'b1);
        drain("mid_rst_drain");
        chk("mid_rst_count", 64'(rsp_tags.size()), 64'(1));
        if (rsp_tags.size() == 1) chk("mid_rst_tag0", 64'(rsp_tags[0]), 64'(0));

        // Tag wrap: 17 commands
        do_reset();
        ra = $urandom; rb = 32'($urandom_range(1, 15)); rop = 3'($urandom_range(0, 5));
        guard = 0;
        while (acc_count < 17 && guard < 200) begin
            drive(1'b1, ra, rb, rop, 1'b1);
            if (acc_count != 0 && q.size() != 0 && q[q.size()-1].tag == tag_model - 1'b1) begin
                ra = $urandom; rb = 32'($urandom_range(1, 15)); rop = 3'($urandom_range(0, 5));
            end
            guard++;
        end
        chk("wrap_accepted", 64'(acc_count), 64'(17));
        drain("wrap_drain");
        chk("wrap_count", 64'(rsp_tags.size()), 64'(17));
        if (rsp_tags.size() == 17) begin
            for (int i = 0; i < 17; i++) chk("wrap_tag", 64'(rsp_tags[i]), 64'(i % 16));
        end

        // Random traffic against the queue model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 32'($urandom_range(1, 15)),
                  3'($urandom_range(0, 5)), 1'($urandom_range(0, 3) != 0));
        end
        drain("rand_drain");
        chk("rand_all_returned", 64'(rsp_ys.size()), 64'(acc_count));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
